// File: rtl/hazard_pipe_regs_pkg.sv
// Shared types for the hazard-aware pipeline registers: per-stage control
// bundles and the all-zero bubble constants loaded on flush and reset.
package hazard_pipe_regs_pkg;

    typedef struct packed {
        logic        arm;
        logic        valid;
        logic        pcsrc;
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  result_src;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_BUBBLE = '0;

    typedef struct packed {
        logic [31:0] instr;
        logic        arm;
        logic        valid;
    } fd_t;

    localparam fd_t FD_BUBBLE = '0;

    // Controls that survive past execute; source registers are no longer needed.
    typedef struct packed {
        logic        arm;
        logic        valid;
        logic        pcsrc;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [4:0]  rd;
    } wb_ctrl_t;

    typedef struct packed {
        wb_ctrl_t    wb;
        logic        mem_write;
    } mem_ctrl_t;

    localparam wb_ctrl_t  WB_BUBBLE  = '0;
    localparam mem_ctrl_t MEM_BUBBLE = '0;

endpackage

// File: rtl/hazard_pipe_regs_stage.sv
// Generic pipeline boundary register: async reset and sync clear both load
// the bubble value; clear wins over enable.
module pipe_stage_reg #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   BUBBLE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= BUBBLE;
        end else if (clear) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_pipe_regs.sv
// F/D, D/E, E/M and M/W pipeline registers with stall/flush handling and a
// retired-instruction counter at writeback.
module hazard_pipe_regs
    import hazard_pipe_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic [31:0] InstrF,
    input  logic        armF,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        PCSrcD,
    input  logic [1:0]  ResultSrcD,
    input  logic [4:0]  RdD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    output logic [31:0] InstrD,
    output logic        armD,
    output logic        armE,
    output logic        armM,
    output logic        armW,
    output logic        PCSrcE,
    output logic        PCSrcM,
    output logic        PCSrcW,
    output logic        RegWriteE,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        MemWriteE,
    output logic        MemWriteM,
    output logic [1:0]  ResultSrcE,
    output logic [1:0]  ResultSrcM,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdE,
    output logic [4:0]  RdM,
    output logic [4:0]  RdW,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic        validD,
    output logic        validE,
    output logic        validM,
    output logic        validW,
    output logic [31:0] RetiredW
);

    fd_t         fd_d, fd_q;
    stage_ctrl_t de_d, de_q;
    mem_ctrl_t   em_d, em_q;
    wb_ctrl_t    mw_d, mw_q;

    // The PC register lives outside this block, so fetch stall has nothing to hold here.
    logic unused_stall_f;
    assign unused_stall_f = StallF;

    assign fd_d = '{instr: InstrF, arm: armF, valid: 1'b1};

    pipe_stage_reg #(.W($bits(fd_t)), .BUBBLE(FD_BUBBLE)) u_fd (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clear (FlushD),
        .d     (fd_d),
        .q     (fd_q)
    );

    assign de_d = '{arm:        fd_q.arm,
                    valid:      fd_q.valid,
                    pcsrc:      PCSrcD,
                    reg_write:  RegWriteD,
                    mem_write:  MemWriteD,
                    result_src: ResultSrcD,
                    rd:         RdD,
                    rs1:        Rs1D,
                    rs2:        Rs2D};

    pipe_stage_reg #(.W($bits(stage_ctrl_t)), .BUBBLE(STAGE_BUBBLE)) u_de (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clear (FlushE),
        .d     (de_d),
        .q     (de_q)
    );

    assign em_d = '{wb: '{arm:        de_q.arm,
                          valid:      de_q.valid,
                          pcsrc:      de_q.pcsrc,
                          reg_write:  de_q.reg_write,
                          result_src: de_q.result_src,
                          rd:         de_q.rd},
                    mem_write: de_q.mem_write};

    pipe_stage_reg #(.W($bits(mem_ctrl_t)), .BUBBLE(MEM_BUBBLE)) u_em (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clear (1'b0),
        .d     (em_d),
        .q     (em_q)
    );

    assign mw_d = em_q.wb;

    pipe_stage_reg #(.W($bits(wb_ctrl_t)), .BUBBLE(WB_BUBBLE)) u_mw (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clear (1'b0),
        .d     (mw_d),
        .q     (mw_q)
    );

    // Counts the instruction sitting in writeback at each edge; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RetiredW <= '0;
        end else if (mw_q.valid) begin
            RetiredW <= RetiredW + 32'd1;
        end
    end

    assign InstrD     = fd_q.instr;
    assign armD       = fd_q.arm;
    assign validD     = fd_q.valid;

    assign armE       = de_q.arm;
    assign validE     = de_q.valid;
    assign PCSrcE     = de_q.pcsrc;
    assign RegWriteE  = de_q.reg_write;
    assign MemWriteE  = de_q.mem_write;
    assign ResultSrcE = de_q.result_src;
    assign RdE        = de_q.rd;
    assign Rs1E       = de_q.rs1;
    assign Rs2E       = de_q.rs2;

    assign armM       = em_q.wb.arm;
    assign validM     = em_q.wb.valid;
    assign PCSrcM     = em_q.wb.pcsrc;
    assign RegWriteM  = em_q.wb.reg_write;
    assign MemWriteM  = em_q.mem_write;
    assign ResultSrcM = em_q.wb.result_src;
    assign RdM        = em_q.wb.rd;

    assign armW       = mw_q.arm;
    assign validW     = mw_q.valid;
    assign PCSrcW     = mw_q.pcsrc;
    assign RegWriteW  = mw_q.reg_write;
    assign ResultSrcW = mw_q.result_src;
    assign RdW        = mw_q.rd;

endmodule
